// File: rtl/prio_heap.sv
// Binary min/max priority heap with a sequential sift engine.
// One insert or extract is accepted per idle cycle.
module prio_heap #(
  parameter int data_wd  = 4,
  parameter int capacity = 8,
  parameter int addr     = 3,
  parameter int max_mode = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               rnw,
  input  logic [data_wd-1:0] wr_data,
  output logic [data_wd-1:0] rd_data,
  output logic               valid,
  output logic               ready,
  output logic [data_wd-1:0] peek_data,
  output logic [addr:0]      count,
  output logic               empty,
  output logic               full,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE,
    SIFT_UP,
    SIFT_DOWN
  } state_t;

  state_t state, state_nx;

  logic [data_wd-1:0] heap [capacity];
  logic [addr-1:0]    cur;
  logic [addr-1:0]    par;
  logic [addr-1:0]    pick;
  logic [addr-1:0]    last;
  logic [addr+1:0]    lidx;
  logic [addr+1:0]    ridx;
  logic               has_l;
  logic               has_r;
  logic               up_swap;
  logic               dn_swap;
  logic               take;

  function automatic logic better(
    input logic [data_wd-1:0] a,
    input logic [data_wd-1:0] b
  );
    if (max_mode != 0) return a > b;
    return a < b;
  endfunction

  assign ready     = (state == IDLE);
  assign empty     = (count == '0);
  assign full      = (count == (addr+1)'(capacity));
  assign peek_data = heap[0];

  // Neighbour indices and the swap decisions for the current node.
  always_comb begin
    par   = (cur - addr'(1)) >> 1;
    last  = count[addr-1:0] - addr'(1);
    lidx  = {1'b0, cur, 1'b1};
    ridx  = lidx + (addr+2)'(1);
    has_l = lidx < {1'b0, count};
    has_r = ridx < {1'b0, count};
    pick  = lidx[addr-1:0];
    if (has_r && better(heap[ridx[addr-1:0]],
                        heap[lidx[addr-1:0]]))
      pick = ridx[addr-1:0];
    dn_swap = has_l && better(heap[pick], heap[cur]);
    up_swap = (cur != '0) && better(heap[cur], heap[par]);
    take    = cs && (rnw ? !empty : !full);
  end

  // Next-state logic: idle until a legal request, sift until settled.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (take) state_nx = rnw ? SIFT_DOWN : SIFT_UP;
      end
      SIFT_UP: begin
        if (!up_swap) state_nx = IDLE;
      end
      SIFT_DOWN: begin
        if (!dn_swap) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Heap storage, occupancy, cursor and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      rd_data <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      cur     <= '0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cs && !take) begin
            err <= 1'b1;
          end else if (take && rnw) begin
            rd_data <= heap[0];
            heap[0] <= heap[last];
            count   <= count - (addr+1)'(1);
            cur     <= '0;
            valid   <= 1'b1;
          end else if (take) begin
            heap[count[addr-1:0]] <= wr_data;
            count <= count + (addr+1)'(1);
            cur   <= count[addr-1:0];
          end
        end
        SIFT_UP: begin
          if (up_swap) begin
            heap[cur] <= heap[par];
            heap[par] <= heap[cur];
            cur       <= par;
          end
        end
        SIFT_DOWN: begin
          if (dn_swap) begin
            heap[cur]  <= heap[pick];
            heap[pick] <= heap[cur];
            cur        <= pick;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/prio_heap.md
PRIO_HEAP -- requirements
Module: prio_heap

Interface
REQ-001 SHALL have parameter data_wd, default 4: element width in bits.
REQ-002 SHALL have parameter capacity, default 8: maximum number of stored elements, 2..2**addr.
REQ-003 SHALL have parameter addr, default 3: index width, with 2**addr >= capacity.
REQ-004 SHALL have parameter max_mode, default 0: 0 means a min-heap with the smallest value at the top; 1 means a max-heap.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port cs, input, 1 bit: request strobe, sampled only when ready=1.
REQ-008 SHALL have port rnw, input, 1 bit: 1 means extract top, 0 means insert wr_data.
REQ-009 SHALL have port wr_data, input, data_wd bits: element to insert.
REQ-010 SHALL have port rd_data, output, data_wd bits, registered: extracted element.
REQ-011 SHALL have port valid, output, 1 bit: one-cycle pulse, rd_data holds an extracted element.
REQ-012 SHALL have port ready, output, 1 bit: 1 when idle and able to accept a request.
REQ-013 SHALL have port peek_data, output, data_wd bits: current top element, meaningful when empty=0.
REQ-014 SHALL have port count, output, addr+1 bits: number of stored elements.
REQ-015 SHALL have ports empty and full, outputs, 1 bit each: empty=(count==0), full=(count==capacity).
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse on a rejected request.

Function
REQ-017 SHALL store elements in a register array indexed 0..capacity-1, with the root at index 0, parent (i-1)/2 and children 2i+1 and 2i+2.
REQ-018 SHALL implement FSM states IDLE, SIFT_UP and SIFT_DOWN; ready SHALL be 1 exactly in IDLE.
REQ-019 SHALL use "better(a,b)" to mean a<b unsigned when max_mode=0 and a>b when max_mode=1; comparison SHALL be strict, so equal values never swap.
REQ-020 On an accepted insert (IDLE, cs=1, rnw=0, full=0), SHALL write wr_data to index count, increment count, set cur to the old count and go to SIFT_UP.
REQ-021 In SIFT_UP, each cycle: if cur!=0 and better(heap[cur], heap[parent]), SHALL swap and set cur=parent; otherwise SHALL go to IDLE.
REQ-022 On an accepted extract (IDLE, cs=1, rnw=1, empty=0), SHALL in that edge load rd_data from heap[0], move heap[count-1] to index 0, decrement count, set cur=0 and go to SIFT_DOWN.
REQ-023 SHALL assert valid in the cycle after an accepted extract edge, for exactly one cycle.
REQ-024 In SIFT_DOWN, each cycle: select the better of the children that lie within count (left child on tie); if that child is better than heap[cur], SHALL swap and set cur=child; otherwise, or if there are no children, SHALL go to IDLE.
REQ-025 Each busy phase SHALL last at most addr+1 cycles; an insert into an empty heap or an extract leaving count<=1 SHALL return to IDLE after one cycle.
REQ-026 An insert when full=1 or an extract when empty=1 SHALL not change the array, count or rd_data, and SHALL pulse err for one cycle with valid staying 0.
REQ-027 A request with cs=1 while ready=0 SHALL be ignored, with no err and no state change; the requester SHALL hold cs until it sees ready.
REQ-028 count, empty, full and peek_data SHALL reflect the updated values from the accepting edge onward; peek_data SHALL be stable only in IDLE.
REQ-029 rd_data SHALL hold its value until the next accepted extract.

Reset
REQ-030 With rst=1 at a clock edge, SHALL set state=IDLE, count=0, rd_data=0, valid=0 and err=0, so ready=1, empty=1 and full=0 in the following cycle.
REQ-031 A reset during SIFT_UP or SIFT_DOWN SHALL abort the operation and discard all contents; array storage need not be cleared.
REQ-032 rst SHALL take priority over a cs request at the same edge.

Verification (data_wd=4, capacity=8, addr=3)
REQ-033 Min-mode order: insert 7,6,5,4,3, waiting for ready each time, then 5 extracts -> rd_data 3,4,5,6,7 with one valid pulse each; count ends at 0 and empty=1.
REQ-034 Max-mode order: max_mode=1, same inserts -> extracts 7,6,5,4,3, and peek_data=7 after the last insert.
REQ-035 Full boundary: insert 8 values -> full=1 and count=8; a 9th insert -> err pulse, count stays 8, and a following extract returns the correct minimum.
REQ-036 Empty boundary: after reset, an extract -> err pulse, valid=0, rd_data stays 0, ready returns to 1 the next cycle.
REQ-037 Duplicates and latency: insert 2,2,1 -> extracts 1,2,2; no busy phase exceeds 4 cycles.
REQ-038 Mid-operation reset: insert 8,7,6,5,4 and assert rst during the SIFT_UP of 4 -> next cycle count=0, ready=1, empty=1; a new insert of 9 -> peek_data=9.
